// File: rtl/qtcore_session_sequencer.sv
// qtcore_session_sequencer: loads a scan image into the core, runs it until halt or budget, unloads the result.
module qtcore_session_sequencer #(
  parameter int CHAIN_LEN = 144,
  parameter int LIMIT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LIMIT_W-1:0] run_limit,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic               scan_enable,
  output logic               scan_in,
  input  logic               scan_out,
  output logic               proc_en,
  input  logic               halt
);
  localparam int NB = CHAIN_LEN / 8;
  localparam int BW = $clog2(NB + 1);
  localparam logic [BW-1:0] LAST = BW'(NB);
  localparam logic [2:0] IDLE = 3'd0, LD_WAIT = 3'd1, LD_SHIFT = 3'd2, RUN = 3'd3,
                         UL_SHIFT = 3'd4, UL_WAIT = 3'd5, DONE = 3'd6;
  logic [2:0] state, bit_cnt;
  logic [BW-1:0] byte_cnt, byte_nx;
  logic [7:0] ld_byte, ul_byte;
  logic [LIMIT_W-1:0] cnt, cnt_nx, lim;
  logic to_r, budget_hit;
  assign byte_nx = byte_cnt + 1'b1;
  assign cnt_nx = cnt + 1'b1;
  // cnt counts completed RUN cycles, so cnt_nx is the number of the current one
  assign budget_hit = (lim != '0) && (cnt_nx == lim);
  assign in_ready = state == LD_WAIT;
  assign out_valid = state == UL_WAIT;
  assign out_data = ul_byte;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign timed_out = to_r;
  assign scan_enable = (state == LD_SHIFT) || (state == UL_SHIFT);
  assign scan_in = (state == LD_SHIFT) & ld_byte[bit_cnt];
  assign proc_en = state == RUN;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      byte_cnt <= '0;
      ld_byte <= '0;
      ul_byte <= '0;
      cnt <= '0;
      lim <= '0;
      to_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= LD_WAIT;
          bit_cnt <= '0;
          byte_cnt <= '0;
          lim <= run_limit;
          to_r <= 1'b0;
        end
        LD_WAIT: if (in_valid) begin
          state <= LD_SHIFT;
          ld_byte <= in_data;
        end
        LD_SHIFT: begin
          bit_cnt <= bit_cnt + 3'd1;
          cnt <= '0;
          if (bit_cnt == 3'd7) begin
            state <= (byte_nx == LAST) ? RUN : LD_WAIT;
            byte_cnt <= (byte_nx == LAST) ? '0 : byte_nx;
          end
        end
        RUN: begin
          cnt <= (&cnt) ? cnt : cnt_nx;
          if (halt || budget_hit) state <= UL_SHIFT;
          if (!halt && budget_hit) to_r <= 1'b1;
        end
        UL_SHIFT: begin
          bit_cnt <= bit_cnt + 3'd1;
          ul_byte <= {scan_out, ul_byte[7:1]};
          if (bit_cnt == 3'd7) begin
            state <= UL_WAIT;
            byte_cnt <= byte_nx;
          end
        end
        UL_WAIT: if (out_ready) state <= (byte_cnt == LAST) ? DONE : UL_SHIFT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qtcore_session_sequencer.sv
// tb_qtcore_session_sequencer: random and directed sessions against a behavioural chain and session model.
module tb_qtcore_session_sequencer;
  localparam int CL = 16, LW = 4, NB = CL / 8;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [LW-1:0] run_limit = '0;
  logic [7:0] in_data = '0, out_data;
  logic in_ready, out_valid, busy, done, timed_out, scan_enable, scan_in, scan_out, proc_en, halt;
  int cmp_n = 0, err_n = 0, cyc = 0, pe_cnt = 0, pe_base = 0, halt_at = 0, in_hs = 0;
  logic [CL-1:0] chain = '0;
  byte unsigned exp_q[$], got_q[$];
  logic prev_stall = 0;
  logic [7:0] prev_data = '0;

  qtcore_session_sequencer #(.CHAIN_LEN(CL), .LIMIT_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_limit(run_limit),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .timed_out(timed_out),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .proc_en(proc_en), .halt(halt)
  );

  always #5 clk = ~clk;
  // chain model: plain shift register, head gets scan_in, tail is chain[0]
  assign scan_out = chain[0];
  assign halt = (halt_at != 0) && (pe_cnt - pe_base + 1 >= halt_at);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (proc_en) pe_cnt <= pe_cnt + 1;
    if (scan_enable) chain <= {scan_in, chain[CL-1:1]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("no_overlap", 32'(scan_enable && proc_en), 0);
      if (!busy || in_ready || out_valid || done) chk("quiet_state", 32'(scan_enable | proc_en), 0);
      if (prev_stall) chk("out_stable", 32'({out_valid, out_data}), 32'({1'b1, prev_data}));
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        in_hs++;
      end
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (exp_q.size() == 0) chk("out_extra", 1, 0);
        else chk("out_byte", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end else begin
      exp_q.delete();
      prev_stall = 0;
    end
  end

  task automatic session(input logic [CL-1:0] img, input int lim, input int hat, input int stall,
                         input bit poke, output int r, output int tot, output logic to);
    int idx = 0, t0, gb, ib, exp_r;
    bit seen = 0, acc;
    logic exp_to;
    r = 0; tot = 0; to = 1'bx;
    halt_at = hat;
    pe_base = pe_cnt;
    gb = got_q.size();
    ib = in_hs;
    @(posedge clk); #1;
    start = 1;
    run_limit = LW'(lim);
    @(posedge clk); #1;
    t0 = cyc;
    start = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (!in_valid && idx < NB && $urandom_range(99) >= stall) begin
        in_valid = 1;
        in_data = img[8*idx +: 8];
      end else if (!in_valid && idx >= NB && poke) begin
        in_valid = 1'($urandom_range(1));
        in_data = 8'($urandom);
      end
      out_ready = $urandom_range(99) >= stall;
      if (poke) start = $urandom_range(3) == 0;
      @(negedge clk);
      if (k == 0) begin
        chk("start_busy", 32'(busy), 1);
        chk("start_in_ready", 32'(in_ready), 1);
        chk("start_clears_to", 32'(timed_out), 0);
      end
      acc = in_valid && in_ready;
      if (acc) idx++;
      if (done) seen = 1;
      @(posedge clk); #1;
      if (acc) in_valid = 0;
    end
    start = 0;
    in_valid = 0;
    out_ready = 0;
    halt_at = 0;
    if (!seen) begin
      chk("done_timeout", 0, 1);
      return;
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
    tot = cyc - t0 + 1;
    to = timed_out;
    r = pe_cnt - pe_base;
    if (hat != 0 && (lim == 0 || hat <= lim)) begin
      exp_r = hat;
      exp_to = 0;
    end else begin
      exp_r = lim;
      exp_to = 1;
    end
    chk("run_cycles", r, exp_r);
    chk("timed_out", 32'(to), 32'(exp_to));
    chk("bytes_in", in_hs - ib, NB);
    chk("bytes_out", got_q.size() - gb, NB);
    for (int i = 0; i < NB && gb + i < got_q.size(); i++)
      chk("byte_order", 32'(got_q[gb+i]), 32'(img[8*i +: 8]));
    if (stall == 0) chk("total_cycles", tot, 18 * NB + exp_r + 2);
  endtask

  task automatic reset_mid(input bit in_run);
    int hits = 0;
    halt_at = 0;
    @(posedge clk); #1;
    start = 1;
    run_limit = '0;
    @(posedge clk); #1;
    start = 0;
    in_valid = 1;
    for (int k = 0; k < 200 && hits < 3; k++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      if (in_run ? proc_en : scan_enable) hits++;
      @(posedge clk); #1;
    end
    chk(in_run ? "reach_run" : "reach_shift", 32'(hits >= 3), 1);
    rst_n = 0;
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("reset_outputs", 32'({in_ready, out_valid, out_data, busy, done, timed_out, scan_enable, scan_in, proc_en}), 0);
    @(negedge clk);
    chk("reset_stays_idle", 32'(busy), 0);
  endtask

  initial begin
    int r, t, lim, hat, stall;
    logic to;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("por_outputs", 32'({in_ready, out_valid, out_data, busy, done, timed_out, scan_enable, scan_in, proc_en}), 0);
    @(posedge clk); #1;
    rst_n = 1;
    session(16'h3CA5, 0, 1, 0, 0, r, t, to);
    chk("rt_run", r, 1);
    chk("rt_total", t, 39);
    chk("rt_to", 32'(to), 0);
    chk("rt_byte0", 32'(got_q[got_q.size()-2]), 32'h A5);
    chk("rt_byte1", 32'(got_q[got_q.size()-1]), 32'h 3C);
    session(16'h5A0F, 0, 7, 0, 0, r, t, to);
    chk("halt_run", r, 7);
    chk("halt_to", 32'(to), 0);
    session(16'hC381, 5, 0, 0, 1, r, t, to);
    chk("budget_run", r, 5);
    chk("budget_to", 32'(to), 1);
    session(16'h1234, 0, 2, 30, 1, r, t, to);
    chk("to_cleared", 32'(to), 0);
    reset_mid(0);
    reset_mid(1);
    session(16'h3CA5, 0, 1, 0, 0, r, t, to);
    chk("fresh_total", t, 39);
    for (int n = 0; n < 30; n++) begin
      lim = $urandom_range(0, 15);
      hat = $urandom_range(0, 20);
      if (lim == 0 && hat == 0) hat = 1;
      stall = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(10, 60);
      session(CL'($urandom), lim, hat, stall, 1'($urandom_range(1)), r, t, to);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
